// File: rtl/seq_divider_pkg.sv
// Shared constants and types for the sequential divider:
// core width, RISC-V divide op encodings and the divider FSM states.
package seq_divider_pkg;

    localparam int XLEN = 32;

    // funct3[1:0] of the RISC-V M-extension divide group
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract iteration.
// Ports: rem_i/rem_o partial remainder (XLEN+1 bits), dvd_msb_i next
// dividend bit shifted in, dvs_i divisor magnitude, q_bit_o quotient bit.
module div_step #(
    parameter int XLEN = seq_divider_pkg::XLEN
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            dvd_msb_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic            q_bit_o,
    output logic [XLEN:0]   rem_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   diff;

    always_comb begin
        shifted = {rem_i, dvd_msb_i};
        q_bit_o = (shifted >= {2'b00, dvs_i});
        // Only taken when shifted >= divisor, so the result fits XLEN+1 bits
        diff    = shifted[XLEN:0] - {1'b0, dvs_i};
        rem_o   = q_bit_o ? diff : shifted[XLEN:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Ports: clk, reset (async, active-high), start/op/dividend/divisor in;
// busy, done (1-cycle pulse), result and div_by_zero (held) out.
module seq_divider #(
    parameter int XLEN = seq_divider_pkg::XLEN,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    import seq_divider_pkg::*;

    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            dbz_out_q, dbz_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            in_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            in_dbz;
    logic            in_ovf;
    logic            accept;

    logic            step_q_bit;
    logic [XLEN:0]   step_rem;

    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fix_res;

    div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_i    (rem_q),
        .dvd_msb_i(dvd_q[XLEN-1]),
        .dvs_i    (dvs_q),
        .q_bit_o  (step_q_bit),
        .rem_o    (step_rem)
    );

    // Operand conditioning for the accepting edge
    always_comb begin
        in_signed = is_signed_op(op);
        a_neg     = in_signed & dividend[XLEN-1];
        b_neg     = in_signed & divisor[XLEN-1];
        a_mag     = a_neg ? (-dividend) : dividend;
        b_mag     = b_neg ? (-divisor) : divisor;
        in_dbz    = (divisor == '0);
        in_ovf    = in_signed && (dividend == MIN_NEG)
                    && (divisor == '1);
        accept    = start
                    && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Sign correction and quotient/remainder select
    always_comb begin
        q_fix = q_neg_q ? (-dvd_q) : dvd_q;
        r_fix = r_neg_q ? (-rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
        if (dbz_q) begin
            // dvd_q still holds the raw dividend on the fast path
            fix_res = is_rem_op(op_q) ? dvd_q : '1;
        end else if (ovf_q) begin
            fix_res = is_rem_op(op_q) ? '0 : MIN_NEG;
        end else begin
            fix_res = is_rem_op(op_q) ? r_fix : q_fix;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        dbz_out_d = dbz_out_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    op_d    = op;
                    dvs_d   = b_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dbz_d   = in_dbz;
                    ovf_d   = in_ovf;
                    if (in_dbz || in_ovf) begin
                        dvd_d   = dividend;
                        state_d = S_FIX;
                    end else begin
                        dvd_d   = a_mag;
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                // Dividend register turns into the quotient, MSB first
                dvd_d = {dvd_q[XLEN-2:0], step_q_bit};
                rem_d = step_rem;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d  = fix_res;
                dbz_out_d = dbz_q;
                state_d   = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            dbz_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            dbz_out_q <= dbz_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model with
// per-cycle output compare, directed literal cases and random operations.
module tb_seq_divider;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;
    localparam int NORM_LAT = 34;
    localparam int FAST_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    int total = 0;
    int bad = 0;

    seq_divider dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s: got %h want %h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // Reference: RISC-V divide semantics in plain arithmetic
    function automatic void ref_div(input logic [1:0] o,
                                    input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] r,
                                    output logic dz,
                                    output int lat);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        bit sgn;
        bit rem;
        sgn = (o == DIV) || (o == REM);
        rem = (o == REM) || (o == REMU);
        sa = a;
        sb = b;
        dz = 1'b0;
        lat = NORM_LAT;
        if (b == 0) begin
            dz = 1'b1;
            lat = FAST_LAT;
            r = rem ? a : 32'hFFFF_FFFF;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lat = FAST_LAT;
            r = rem ? 32'h0 : 32'h8000_0000;
        end else if (sgn) begin
            r = rem ? 32'(sa % sb) : 32'(sa / sb);
        end else begin
            r = rem ? (a % b) : (a / b);
        end
    endfunction

    // Model: cycles since accept (-1 idle), latency and held outputs
    int          m_k = -1;
    int          m_lat = 0;
    logic [31:0] m_res = '0;
    logic        m_dbz = 1'b0;
    logic [31:0] m_pres = '0;
    logic        m_pdbz = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k = -1;
            m_res = '0;
            m_dbz = 1'b0;
        end else if (start && (m_k < 0 || m_k == m_lat)) begin
            ref_div(op, dividend, divisor, m_pres, m_pdbz, m_lat);
            m_k = 1;
        end else if (m_k >= 1 && m_k < m_lat) begin
            m_k++;
            if (m_k == m_lat) begin
                m_res = m_pres;
                m_dbz = m_pdbz;
            end
        end else if (m_k == m_lat) begin
            m_k = -1;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_k >= 1 && m_k < m_lat));
        chk("done", 32'(done), 32'(m_k == m_lat));
        chk("result", result, m_res);
        chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit lit,
                          input logic [31:0] er, input bit ed,
                          input int el, input bit sync,
                          input string nm);
        int n;
        bit got;
        if (sync) begin
            @(posedge clk);
            #2;
        end
        op = o;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        op = 2'($urandom);
        dividend = $urandom;
        divisor = $urandom;
        n = 1;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else n++;
        end
        chk({nm, " done seen"}, 32'(got), 32'd1);
        if (lit) begin
            chk({nm, " latency"}, n, el);
            chk({nm, " result"}, result, er);
            chk({nm, " dbz"}, 32'(div_by_zero), 32'(ed));
        end
    endtask

    initial begin
        int fd;
        logic [31:0] rs;
        logic [1:0] o;
        logic [31:0] a;
        logic [31:0] b;
        int sel;

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset dbz", 32'(div_by_zero), 32'd0);
        #1;
        reset = 1'b0;

        // accepted on the first edge after reset release
        run_op(DIVU, 100, 7, 1, 14, 0, 34, 0, "divu 100/7");
        run_op(REMU, 100, 7, 1, 2, 0, 34, 1, "remu 100/7");
        run_op(DIV, 32'hFFFF_FFF9, 2, 1, 32'hFFFF_FFFD, 0, 34, 1,
               "div -7/2");
        run_op(REM, 32'hFFFF_FFF9, 2, 1, 32'hFFFF_FFFF, 0, 34, 1,
               "rem -7/2");
        run_op(DIV, 7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 0, 34, 1,
               "div 7/-2");
        run_op(DIVU, 5, 0, 1, 32'hFFFF_FFFF, 1, 2, 1, "divu 5/0");
        run_op(REM, 5, 0, 1, 5, 1, 2, 1, "rem 5/0");
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0,
               2, 1, "div ovf");
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0, 2, 1,
               "rem ovf");
        run_op(DIVU, 3, 10, 1, 0, 0, 34, 1, "divu 3/10");
        run_op(REMU, 3, 10, 1, 3, 0, 34, 1, "remu 3/10");
        run_op(REM, 32'hFFFF_FFFD, 10, 1, 32'hFFFF_FFFD, 0, 34, 1,
               "rem -3/10");

        // back-to-back: second start in the DONE cycle of the first
        run_op(DIVU, 1000, 10, 1, 100, 0, 34, 1, "b2b first");
        run_op(REMU, 1000, 7, 1, 6, 0, 34, 0, "b2b second");

        // starts while busy and operand churn are ignored
        @(posedge clk);
        #2;
        op = DIVU;
        dividend = 100;
        divisor = 7;
        start = 1'b1;
        fd = -1;
        rs = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #2;
            start = (c == 5 || c == 20);
            op = 2'($urandom);
            dividend = $urandom;
            divisor = $urandom;
            @(negedge clk);
            if (done && fd < 0) begin
                fd = c;
                rs = result;
            end
        end
        start = 1'b0;
        chk("ignore start latency", fd, 34);
        chk("ignore start result", rs, 14);

        // reset in the middle of an operation
        @(posedge clk);
        #2;
        op = DIVU;
        dividend = 100;
        divisor = 7;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset result", result, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        run_op(DIVU, 9, 3, 1, 3, 0, 34, 0, "divu 9/3");

        for (int i = 0; i < 150; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 15);
            if (sel <= 1) b = 0;
            else if (sel == 2) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 3) b = $urandom_range(1, 15);
            else if (sel == 4) a = $urandom_range(0, 100);
            if ($urandom_range(0, 3) != 0) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                run_op(o, a, b, 0, 0, 0, 0, 1, "rand");
            end else begin
                run_op(o, a, b, 0, 0, 0, 0, 0, "rand b2b");
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
